// File: rtl/speaker_arbiter.sv
// speaker_arbiter
// Shares the single board speaker pin between several game-event requesters.
// Tone requests arrive over a valid/ready handshake; requester 0 has the
// highest priority and a higher-priority request may preempt a playing tone.
// The accepted tone is a square wave of the requested half-period (in
// pixel_clk cycles) that lasts for the requested number of duration ticks.
//
// Ports:
//   pixel_clk        only clock
//   rst              asynchronous active-high reset
//   req_valid        per-requester request valid
//   req_half_period  packed half-periods, requester i at [i*HP_W +: HP_W]
//   req_duration     packed durations,    requester i at [i*DUR_W +: DUR_W]
//   req_ready        combinational grant, one-hot or zero
//   mute             forces speaker low without disturbing sequencing
//   speaker          registered square-wave output
//   busy             registered, high while a tone is playing
//   active_id        registered index of the most recently accepted tone

module speaker_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HP_W     = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 36000
) (
  input  logic                         pixel_clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*HP_W-1:0]        req_half_period,
  input  logic [N_REQ*DUR_W-1:0]       req_duration,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         mute,
  output logic                         speaker,
  output logic                         busy,
  output logic [$clog2(N_REQ)-1:0]     active_id
);

  localparam int ID_W = $clog2(N_REQ);
  // A divide-by-one prescaler still needs a one-bit register to exist.
  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state, state_next;
  logic [HP_W-1:0]    hp_q, hp_next;
  logic [HP_W-1:0]    tone_cnt, tone_cnt_next;
  logic [DUR_W-1:0]   remain, remain_next;
  logic [PS_W-1:0]    presc, presc_next;
  logic               phase, phase_next;
  logic [ID_W-1:0]    id_next;

  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [HP_W-1:0]    grant_hp;
  logic [DUR_W-1:0]   grant_dur;

  // Fixed-priority grant. In IDLE any requester may win; while playing only
  // requesters strictly above the current tone's priority may preempt it.
  // The loop runs from the lowest priority upward so the last hit, which is
  // the lowest index, is the one that sticks.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_hp  = '0;
    grant_dur = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && ((state == IDLE) || (ID_W'(i) < active_id))) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(i);
        grant_hp  = req_half_period[i*HP_W +: HP_W];
        grant_dur = req_duration[i*DUR_W +: DUR_W];
      end
    end
  end

  assign req_ready = grant_any ? (N_REQ'(1) << grant_idx) : '0;

  // Next-state logic. An accepted request always wins over the running
  // tone, so a preemption that lands on the expiry cycle carries straight
  // on into the new tone without passing through IDLE.
  always_comb begin
    state_next    = state;
    hp_next       = hp_q;
    tone_cnt_next = tone_cnt;
    remain_next   = remain;
    presc_next    = presc;
    phase_next    = phase;
    id_next       = active_id;

    if (grant_any) begin
      hp_next       = grant_hp;
      remain_next   = grant_dur;
      id_next       = grant_idx;
      tone_cnt_next = '0;
      presc_next    = '0;
      phase_next    = 1'b0;
      // A zero-length request is consumed but plays nothing.
      state_next    = (grant_dur != '0) ? PLAY : IDLE;
    end else if (state == PLAY) begin
      // A zero half-period is a silent rest of the requested length.
      if (hp_q == '0) begin
        tone_cnt_next = '0;
        phase_next    = 1'b0;
      end else if (tone_cnt == hp_q - HP_W'(1)) begin
        tone_cnt_next = '0;
        phase_next    = ~phase;
      end else begin
        tone_cnt_next = tone_cnt + HP_W'(1);
      end

      if (presc == PS_LAST) begin
        presc_next  = '0;
        remain_next = remain - DUR_W'(1);
        if (remain == DUR_W'(1)) begin
          state_next    = IDLE;
          tone_cnt_next = '0;
          phase_next    = 1'b0;
        end
      end else begin
        presc_next = presc + PS_W'(1);
      end
    end
  end

  // State and output registers. speaker and busy are computed from the
  // next-state values so both change on the same edge as the state itself,
  // which keeps speaker low from the very first IDLE cycle.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hp_q      <= '0;
      tone_cnt  <= '0;
      remain    <= '0;
      presc     <= '0;
      phase     <= 1'b0;
      active_id <= '0;
      speaker   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      hp_q      <= hp_next;
      tone_cnt  <= tone_cnt_next;
      remain    <= remain_next;
      presc     <= presc_next;
      phase     <= phase_next;
      active_id <= id_next;
      speaker   <= phase_next & ~mute & (state_next == PLAY);
      busy      <= (state_next == PLAY);
    end
  end

endmodule

// File: doc/speaker_arbiter.md
# speaker_arbiter

Sound-effect controller that shares the single board `speaker` output between several game-event requesters. It sits between the game logic and the speaker pin and runs in the `pixel_clk` domain. It accepts tone requests over a valid/ready handshake and arbitrates between them with fixed priority and preemption. It produces a square wave at the requested half-period for the requested duration.

## Interface
- `N_REQ`, default 4: number of requesters. Index 0 has the highest priority.
- `HP_W`, default 16: width of the half-period field, in `pixel_clk` cycles.
- `DUR_W`, default 8: width of the duration field, in ticks.
- `TICK_DIV`, default 36000: `pixel_clk` cycles per duration tick (1 ms at 36 MHz).

Ports:
- `pixel_clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_half_period` in N_REQ*HP_W: packed, requester i at `[i*HP_W +: HP_W]`.
- `req_duration` in N_REQ*DUR_W: packed, requester i at `[i*DUR_W +: DUR_W]`.
- `req_ready` out N_REQ: combinational, one-hot or zero. Transfer occurs on a clock edge where `req_valid[i] & req_ready[i]`.
- `mute` in 1: forces `speaker` low; sequencing is unaffected.
- `speaker` out 1: registered square-wave output.
- `busy` out 1: registered, high while in PLAY.
- `active_id` out $clog2(N_REQ): registered index of the tone currently playing.

## Operation
- States: IDLE, PLAY.
- **IDLE**
  - `req_ready[w]` = 1 for w = lowest index with `req_valid` set; all others 0.
  - On transfer:
    - latch hp and dur;
    - `active_id` <= w;
    - tone counter, tick prescaler and tone phase <= 0.
  - If dur != 0, go to PLAY.
  - If dur == 0, the request is consumed and the block stays in IDLE with `busy` = 0.
- **PLAY**
  - `req_ready[w]` = 1 only for the lowest valid index w < `active_id` (preemption).
  - Equal or lower priority requesters see ready = 0 and hold until IDLE.
  - A preempting transfer reloads everything exactly as an IDLE accept does.
  - A preempting request with dur == 0 returns to IDLE.
- **Tone generation**
  - Tone counter increments every cycle in PLAY.
  - When counter == hp-1: counter <= 0 and phase toggles. Period = 2*hp cycles.
  - hp == 0 means silence: phase stays 0 for the full duration.
- **Duration**
  - Prescaler wraps at TICK_DIV-1 and produces a tick.
  - On a tick, the remaining count decrements.
  - When the tick takes the remaining count from 1 to 0, go to IDLE.
- **Output:** `speaker` = phase & ~mute & (state==PLAY). It returns to 0 on entry to IDLE.
- **Simultaneous events:** preemption in the same cycle as expiry wins; the new tone plays with no IDLE cycle in between.
- **Arithmetic:** unsigned, with no overflow. Counters are sized for HP_W, DUR_W and $clog2(TICK_DIV).
- **Reset (any time, including mid-tone):** all state goes to IDLE immediately. `speaker`, `busy` and `active_id` = 0. All counters = 0.

## Timing
- Accept edge E:
  - `busy` = 1 from E+1 (registered).
  - First `speaker` rise is hp cycles after E.
  - `busy` stays high for exactly dur*TICK_DIV cycles.
  - `speaker` is forced to 0 in the same cycle `busy` falls.
- `req_ready` is combinational from state, `active_id` and `req_valid`, with zero-cycle latency. It does not depend on the hp or dur values.
- In the cycle `busy` falls, a pending request is accepted. The next tone's `busy` rises one cycle later, giving one IDLE cycle.
- `mute` takes effect on `speaker` one cycle after it changes.

## Test plan
All scenarios use TICK_DIV=10 and N_REQ=4.
- **Basic tone:** req0 hp=5 dur=3 in IDLE -> `req_ready[0]` high one cycle, `busy` high 30 cycles, `speaker` high/low every 5 cycles (3 full periods), `speaker`=0 and `busy`=0 afterwards.
- **Preemption:** req2 hp=4 dur=5 playing, then req1 hp=3 dur=2 asserted at cycle 12 -> `req_ready[1]` pulses, `active_id`=1, `busy` stays high 20 more cycles, phase restarts with first rise 3 cycles after accept.
- **Blocking:** req1 dur=2 playing, req3 held valid -> `req_ready[3]`=0 throughout. It is accepted in the cycle `busy` falls, then `active_id`=3 and `busy` rises one cycle later.
- **Simultaneous requests:** req0 and req2 valid together in IDLE -> only `req_ready[0]`. req2 stays pending and plays after req0 completes.
- **Degenerate fields:** dur=0 -> ready pulses, `busy` stays 0. hp=0 dur=2 -> `busy` high 20 cycles, `speaker` stays 0.
- **Mute and reset:** `mute`=1 during a tone -> `speaker` 0 while `busy` still drops on schedule. `rst` pulse mid-tone -> `speaker`, `busy` and `active_id` go to 0 immediately, and a new req accepted after release plays normally.
